field_merge_scheduler: RTL and testbench
========================================

Name: field_merge_scheduler

Overview:
- Sequences the encoded-byte lanes of the protobuf serializer (varint lane, raw-data lane, and any future lanes) into the single shared output byte FIFO.
- Fields are emitted in strictly ascending field-index order, starting at 0.
- One lane is granted per field, and that field's bytes are streamed until the lane's last-byte marker.
- Sits between the per-encoder output FIFOs and the output FIFO read by the AXI read-side FSM.

Parameters:
- NUM_LANES, 2, number of encoder output lanes (lane 0 = varint, lane 1 = raw data).
- IDX_W, 10, field-index width.
- CNT_W, 16, width of the emitted-byte counter.

Ports:
- clock_clk  in  1  clock; single domain, all logic on rising edge.
- reset_reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a message. Ignored unless idle.
- num_fields  in  IDX_W  number of fields in the message, sampled on an accepted start.
- lane_valid  in  NUM_LANES  lane i FIFO non-empty (head byte present).
- lane_data  in  NUM_LANES*8  head byte of each lane.
- lane_index  in  NUM_LANES*IDX_W  field index of each lane's head byte.
- lane_last  in  NUM_LANES  head byte is the final byte of its field.
- lane_pop  out  NUM_LANES  pops lane i head (one-hot or zero).
- out_data  out  8  byte to the output FIFO.
- out_push  out  1  write strobe to the output FIFO.
- out_full  in  1  output FIFO full.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at message completion.
- err  out  1  sticky missing-field error; cleared by the next accepted start.
- byte_count  out  CNT_W  bytes pushed in the current message; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: lane_pop=0, out_push=0, out_data=0, busy=0, done=0, err=0, byte_count=0, cur_idx=0, state=IDLE.
- Reset mid-message aborts immediately. Nothing is popped or pushed in the reset cycle or after it.
- States: IDLE, SEARCH, STREAM, FINISH.
- IDLE:
  - On start: latch num_fields, clear cur_idx, byte_count and err, set busy.
  - If num_fields==0 go to FINISH, else go to SEARCH.
- SEARCH (one cycle per field minimum):
  - match[i] = lane_valid[i] && lane_index[i]==cur_idx.
  - Grant the lowest i with match[i] set; latch it as gnt and go to STREAM.
  - If no lane matches and all lanes are valid, the field is missing: set err and go to FINISH.
  - If no lane matches and some lane is not valid, stay in SEARCH and wait.
- STREAM:
  - out_push = lane_valid[gnt] && !out_full; lane_pop[gnt] = out_push; out_data = lane_data[gnt] (combinational mux).
  - byte_count increments on each push.
  - On a push with lane_last[gnt]=1, increment cur_idx. If the new cur_idx==num_fields go to FINISH, else go to SEARCH.
  - When out_full=1 or the lane is empty: hold, no push, no pop, no state change.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Throughput: 1 byte/cycle within a field; one bubble cycle between fields.
- Two lanes matching the same cur_idx: the lower lane wins. The other lane is served only if its index matches a later cur_idx; otherwise it triggers a missing-field err later.
- A start pulse while busy is ignored; state and counters are unaffected.
- out_full rising on the same cycle as a lane's last byte: no push and no index advance; the last byte is retried next cycle.
- cur_idx comparison uses the full IDX_W. num_fields up to 2^IDX_W-1 is supported.

Decomposition:
- Shared package serializer_pkg holds:
  - state enum (IDLE, SEARCH, STREAM, FINISH);
  - IDX_W default;
  - lane-number constants LANE_VARINT=0 and LANE_RAW=1.
- One natural sub-module, lane_index_match: a combinational comparator bank plus lowest-index priority encoder. It outputs a match_any flag and a grant index.
- The FSM, counters and output mux stay in field_merge_scheduler.

Test Plan:
1. num_fields=3. Lane0 holds idx0 {0x08}, idx2 {0x96,0x01}; lane1 holds idx1 {0x61,0x62}. Expect out_data sequence 08,61,62,96,01, byte_count=5, done pulse, err=0.
2. Same stimulus with out_full held high for 4 cycles mid-field-1. Expect no push or pop during the stall, identical byte order afterward, byte_count=5.
3. num_fields=2 with both lanes valid and no idx1 present (lane0 head idx2, lane1 head idx3). Expect bytes for idx0 only, then err=1 and done; lane heads are not popped.
4. num_fields=0 start. Expect done exactly 2 cycles after start, no pushes, byte_count=0.
5. Assert reset_reset during STREAM after 2 bytes. Expect all outputs at reset values the next cycle, then a fresh start completing a 1-field message correctly.
6. A second start pulse while busy is ignored. Expect num_fields unchanged and a single done pulse.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the protobuf serializer datapath: scheduler states,
// field-index width default and lane numbering.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEFAULT_IDX_W = 10;

  localparam int LANE_VARINT = 0;
  localparam int LANE_RAW    = 1;

  // Width of a lane number; a single-lane build still needs a 1-bit grant.
  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_index_match.sv
// Compares every lane's head field index against the current field index and
// grants the lowest-numbered matching lane.
module lane_index_match
  import serializer_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int IDX_W     = DEFAULT_IDX_W,
  parameter int GNT_W     = gnt_width(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES*IDX_W-1:0] lane_index,
  input  logic [IDX_W-1:0]           cur_idx,
  output logic                       match_any,
  output logic [GNT_W-1:0]           gnt
);

  logic [NUM_LANES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      match[i] = lane_valid[i] && (lane_index[i*IDX_W +: IDX_W] == cur_idx);
    end
  end

  // Scan from the top so the lowest matching lane is the last one written.
  always_comb begin
    match_any = |match;
    gnt       = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (match[i]) begin
        gnt = GNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/field_merge_scheduler.sv
// Merges per-encoder byte lanes into the shared output FIFO, emitting whole
// fields in ascending field-index order.
module field_merge_scheduler
  import serializer_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int IDX_W     = DEFAULT_IDX_W,
  parameter int CNT_W     = 16
) (
  input  logic                       clock_clk,
  input  logic                       reset_reset,
  input  logic                       start,
  input  logic [IDX_W-1:0]           num_fields,
  input  logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES*8-1:0]     lane_data,
  input  logic [NUM_LANES*IDX_W-1:0] lane_index,
  input  logic [NUM_LANES-1:0]       lane_last,
  output logic [NUM_LANES-1:0]       lane_pop,
  output logic [7:0]                 out_data,
  output logic                       out_push,
  input  logic                       out_full,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [CNT_W-1:0]           byte_count
);

  localparam int GNT_W = gnt_width(NUM_LANES);

  state_t           state;
  logic [IDX_W-1:0] num_fields_q;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] next_idx;
  logic [GNT_W-1:0] gnt_q;
  logic [GNT_W-1:0] gnt_w;
  logic             match_any;
  logic             streaming;
  logic             head_valid;
  logic             head_last;

  lane_index_match #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W),
    .GNT_W     (GNT_W)
  ) u_match (
    .lane_valid (lane_valid),
    .lane_index (lane_index),
    .cur_idx    (cur_idx),
    .match_any  (match_any),
    .gnt        (gnt_w)
  );

  // The handshake is combinational so a field streams at one byte per cycle;
  // reset gates it so an aborted message never pops or pushes.
  assign streaming  = (state == STREAM) && !reset_reset;
  assign head_valid = lane_valid[gnt_q];
  assign head_last  = lane_last[gnt_q];
  assign out_push   = streaming && head_valid && !out_full;
  assign next_idx   = cur_idx + 1'b1;

  always_comb begin
    lane_pop = '0;
    out_data = '0;
    if (streaming) begin
      out_data = lane_data[8*int'(gnt_q) +: 8];
    end
    if (out_push) begin
      lane_pop[gnt_q] = 1'b1;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_count <= '0;
      cur_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_fields_q <= num_fields;
            cur_idx      <= '0;
            byte_count   <= '0;
            err          <= 1'b0;
            busy         <= 1'b1;
            state        <= (num_fields == '0) ? FINISH : SEARCH;
          end
        end
        SEARCH: begin
          if (match_any) begin
            gnt_q <= gnt_w;
            state <= STREAM;
          end else if (&lane_valid) begin
            // Every lane has a head byte yet none carries this field.
            err   <= 1'b1;
            state <= FINISH;
          end
        end
        STREAM: begin
          if (out_push) begin
            byte_count <= byte_count + 1'b1;
            if (head_last) begin
              cur_idx <= next_idx;
              state   <= (next_idx == num_fields_q) ? FINISH : SEARCH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_merge_scheduler.sv
// Scoreboard bench for field_merge_scheduler: lane FIFOs modelled as queues,
// expected output bytes queued by the stimulus and checked by a monitor.
module tb_field_merge_scheduler;

  localparam int NUM_LANES = 2;
  localparam int IDX_W     = 10;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [7:0]       d;
    logic [IDX_W-1:0] idx;
    logic             last;
  } ent_t;

  logic                       clock_clk   = 1'b0;
  logic                       reset_reset = 1'b1;
  logic                       start       = 1'b0;
  logic [IDX_W-1:0]           num_fields  = '0;
  logic [NUM_LANES-1:0]       lane_valid  = '0;
  logic [NUM_LANES*8-1:0]     lane_data   = '0;
  logic [NUM_LANES*IDX_W-1:0] lane_index  = '0;
  logic [NUM_LANES-1:0]       lane_last   = '0;
  logic [NUM_LANES-1:0]       lane_pop;
  logic [7:0]                 out_data;
  logic                       out_push;
  logic                       out_full    = 1'b0;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [CNT_W-1:0]           byte_count;

  field_merge_scheduler #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .start       (start),
    .num_fields  (num_fields),
    .lane_valid  (lane_valid),
    .lane_data   (lane_data),
    .lane_index  (lane_index),
    .lane_last   (lane_last),
    .lane_pop    (lane_pop),
    .out_data    (out_data),
    .out_push    (out_push),
    .out_full    (out_full),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .byte_count  (byte_count)
  );

  always #5 clock_clk = ~clock_clk;

  ent_t       lq0[$];
  ent_t       lq1[$];
  logic [7:0] exp_q[$];
  int tests  = 0;
  int fails  = 0;
  int pushes = 0;
  int dones  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void add(input int lane, input logic [7:0] d, input int idx, input bit last);
    ent_t e;
    e.d    = d;
    e.idx  = IDX_W'(idx);
    e.last = last;
    if (lane == 0) lq0.push_back(e);
    else           lq1.push_back(e);
  endfunction

  function automatic void refresh();
    lane_valid = {lq1.size() > 0, lq0.size() > 0};
    if (lq0.size() > 0) begin
      lane_data[7:0]        = lq0[0].d;
      lane_index[IDX_W-1:0] = lq0[0].idx;
      lane_last[0]          = lq0[0].last;
    end
    if (lq1.size() > 0) begin
      lane_data[15:8]             = lq1[0].d;
      lane_index[2*IDX_W-1:IDX_W] = lq1[0].idx;
      lane_last[1]                = lq1[0].last;
    end
  endfunction

  // Monitor and lane-FIFO model: sample just before the edge, act just after.
  logic                 push_s, full_s, rst_s;
  logic [NUM_LANES-1:0] pop_s;
  logic [7:0]           data_s;
  always begin
    @(negedge clock_clk);
    #4;
    push_s = out_push;
    pop_s  = lane_pop;
    data_s = out_data;
    full_s = out_full;
    rst_s  = reset_reset;
    @(posedge clock_clk);
    #1;
    if (rst_s) begin
      check("rst_push", 32'(push_s), 32'd0);
      check("rst_pop", 32'(pop_s), 32'd0);
    end
    if (full_s) begin
      check("stall_push", 32'(push_s), 32'd0);
      check("stall_pop", 32'(pop_s), 32'd0);
    end
    if (push_s || (|pop_s)) check("pop_vs_push", 32'(|pop_s), 32'(push_s));
    if (push_s) begin
      pushes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL byte: got %02h expected none", data_s);
      end else begin
        check("byte", 32'(data_s), 32'(exp_q.pop_front()));
      end
    end
    if (pop_s[0] && lq0.size() > 0) void'(lq0.pop_front());
    if (pop_s[1] && lq1.size() > 0) void'(lq1.pop_front());
    if (done) dones++;
    refresh();
  end

  task automatic pulse_start(input int n);
    @(negedge clock_clk);
    num_fields = IDX_W'(n);
    start      = 1'b1;
    @(negedge clock_clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen = 0;
    for (int c = 0; c < max && !seen; c++) begin
      @(posedge clock_clk);
      #2;
      if (done) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: done not seen within %0d cycles", max);
    end
  endtask

  task automatic wait_pushes(input int target, input int max);
    int c = 0;
    while (pushes < target && c < max) begin
      @(negedge clock_clk);
      c++;
    end
    check("push_progress", 32'(pushes >= target), 32'd1);
  endtask

  task automatic load_basic();
    add(0, 8'h08, 0, 1);
    add(0, 8'h96, 2, 0);
    add(0, 8'h01, 2, 1);
    add(1, 8'h61, 1, 0);
    add(1, 8'h62, 1, 1);
    exp_q = '{8'h08, 8'h61, 8'h62, 8'h96, 8'h01};
  endtask

  int d0;
  int p0;

  initial begin
    // Reset state
    repeat (3) @(negedge clock_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    check("rst_out_push", 32'(out_push), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_lane_pop", 32'(lane_pop), 32'd0);
    reset_reset = 1'b0;

    // 1: three fields across two lanes
    load_basic();
    @(negedge clock_clk);
    d0 = dones;
    pulse_start(3);
    wait_done(100);
    check("t1_count", 32'(byte_count), 32'd5);
    check("t1_err", 32'(err), 32'd0);
    repeat (3) @(negedge clock_clk);
    check("t1_left", 32'(exp_q.size()), 32'd0);
    check("t1_dones", 32'(dones - d0), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: same message, output FIFO full for 4 cycles inside field 1
    load_basic();
    @(negedge clock_clk);
    p0 = pushes;
    pulse_start(3);
    wait_pushes(p0 + 2, 50);
    out_full = 1'b1;
    repeat (4) @(negedge clock_clk);
    out_full = 1'b0;
    check("t2_stalled", 32'(pushes - p0), 32'd2);
    wait_done(100);
    check("t2_count", 32'(byte_count), 32'd5);
    check("t2_err", 32'(err), 32'd0);
    repeat (2) @(negedge clock_clk);
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // 3: field 1 missing while both lanes are valid
    add(0, 8'h11, 0, 1);
    add(0, 8'h22, 2, 1);
    add(1, 8'h33, 3, 1);
    exp_q = '{8'h11};
    @(negedge clock_clk);
    pulse_start(2);
    wait_done(100);
    check("t3_err", 32'(err), 32'd1);
    check("t3_count", 32'(byte_count), 32'd1);
    repeat (2) @(negedge clock_clk);
    check("t3_lane0_kept", 32'(lq0.size()), 32'd1);
    check("t3_lane1_kept", 32'(lq1.size()), 32'd1);
    check("t3_err_sticky", 32'(err), 32'd1);
    lq0.delete();
    lq1.delete();
    repeat (2) @(negedge clock_clk);

    // 4: empty message, done two edges after start
    p0 = pushes;
    @(negedge clock_clk);
    num_fields = '0;
    start      = 1'b1;
    @(posedge clock_clk);
    #2;
    check("t4_done_early", 32'(done), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_err_cleared", 32'(err), 32'd0);
    @(negedge clock_clk);
    start = 1'b0;
    @(posedge clock_clk);
    #2;
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy_end", 32'(busy), 32'd0);
    check("t4_count", 32'(byte_count), 32'd0);
    check("t4_pushes", 32'(pushes - p0), 32'd0);

    // 5: reset while streaming, then a fresh one-field message
    add(0, 8'hAA, 0, 0);
    add(0, 8'hBB, 0, 0);
    add(0, 8'hCC, 0, 0);
    add(0, 8'hDD, 0, 1);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clock_clk);
    p0 = pushes;
    pulse_start(1);
    wait_pushes(p0 + 2, 50);
    reset_reset = 1'b1;
    @(posedge clock_clk);
    #2;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_count", 32'(byte_count), 32'd0);
    check("t5_out_push", 32'(out_push), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd0);
    check("t5_lane_pop", 32'(lane_pop), 32'd0);
    check("t5_pushes", 32'(pushes - p0), 32'd2);
    exp_q.delete();
    lq0.delete();
    @(negedge clock_clk);
    reset_reset = 1'b0;
    add(1, 8'h55, 0, 1);
    exp_q = '{8'h55};
    @(negedge clock_clk);
    pulse_start(1);
    wait_done(100);
    check("t5b_count", 32'(byte_count), 32'd1);
    check("t5b_err", 32'(err), 32'd0);
    repeat (2) @(negedge clock_clk);
    check("t5b_left", 32'(exp_q.size()), 32'd0);

    // 6: a start pulse while busy is ignored
    add(0, 8'h01, 0, 1);
    exp_q = '{8'h01, 8'h02};
    @(negedge clock_clk);
    d0 = dones;
    pulse_start(2);
    repeat (4) @(negedge clock_clk);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_count_mid", 32'(byte_count), 32'd1);
    pulse_start(5);
    @(negedge clock_clk);
    check("t6_count_after_start", 32'(byte_count), 32'd1);
    add(1, 8'h02, 1, 1);
    wait_done(100);
    check("t6_count", 32'(byte_count), 32'd2);
    check("t6_err", 32'(err), 32'd0);
    repeat (5) @(negedge clock_clk);
    check("t6_dones", 32'(dones - d0), 32'd1);
    check("t6_busy_end", 32'(busy), 32'd0);
    check("t6_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
